// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : PC, instruction-memory and IF/ID handshake bundle for the fetch unit.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_write;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus4;
  logic              fetch_err;

  // The fetch unit itself
  modport master (
    input  pc_in, flush, imem_ack, imem_rdata, id_ready,
    output pc_write, imem_req, imem_addr, id_valid, id_instr, id_pc,
           id_pc_plus4, fetch_err
  );

  // PC register, instruction memory and ID stage
  modport slave (
    output pc_in, flush, imem_ack, imem_rdata, id_ready,
    input  pc_write, imem_req, imem_addr, id_valid, id_instr, id_pc,
           id_pc_plus4, fetch_err
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Fetches one instruction per request from a variable-latency
//            memory into a one-entry IF/ID register, with flush handling.
// Revision : 1.0
// ============================================================================
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  wire                        clk_i,
  input  wire                        reset_i,
  instruction_fetch_unit_if.master   bus_io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

  state_e              state_q,    state_d;
  logic                req_q,      req_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                valid_q,    valid_d;
  logic [DATA_W-1:0]   instr_q,    instr_d;
  logic [ADDR_W-1:0]   pc_q,       pc_d;
  logic [ADDR_W-1:0]   pc_plus4_q, pc_plus4_d;
  logic                err_q,      err_d;

  logic                slot_free_w;
  logic                pc_write_w;

  assign slot_free_w = !valid_q || bus_io.id_ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_WORD;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    err_d      = 1'b0;
    pc_write_w = 1'b0;

    if (valid_q && bus_io.id_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus_io.flush) begin
          pc_write_w = 1'b1;
        end else if (bus_io.pc_in[1:0] != 2'b00) begin
          err_d = 1'b1;
        end else if (slot_free_w) begin
          req_d   = 1'b1;
          addr_d  = bus_io.pc_in;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (bus_io.imem_ack) begin
          pc_write_w = 1'b1;
          req_d      = 1'b0;
          state_d    = S_IDLE;
          if (!bus_io.flush) begin
            valid_d    = 1'b1;
            instr_d    = bus_io.imem_rdata;
            pc_d       = addr_q;
            pc_plus4_d = addr_q + c_pc_step;
          end
        end else if (bus_io.flush) begin
          pc_write_w = 1'b1;
          state_d    = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // The request stays up until the memory answers; its data is dropped.
        if (bus_io.flush) begin
          pc_write_w = 1'b1;
        end
        if (bus_io.imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (bus_io.flush) begin
      valid_d = 1'b0;
    end
  end

  assign bus_io.pc_write    = pc_write_w && !reset_i;
  assign bus_io.imem_req    = req_q;
  assign bus_io.imem_addr   = addr_q;
  assign bus_io.id_valid    = valid_q;
  assign bus_io.id_instr    = instr_q;
  assign bus_io.id_pc       = pc_q;
  assign bus_io.id_pc_plus4 = pc_plus4_q;
  assign bus_io.fetch_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed bench for instruction_fetch_unit with hand-computed values.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch_unit;

  logic clk_i;
  logic reset_i;
  int   checks;
  int   errors;

  instruction_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instruction_fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus_io (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_i         = 1'b1;
    bus.pc_in       = 32'h0;
    bus.flush       = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.id_ready    = 1'b1;

    // Reset values, with flush high to show pc_write is held low in reset
    #2;
    chk("rst_req",      bus.imem_req,    0);
    chk("rst_addr",     bus.imem_addr,   0);
    chk("rst_valid",    bus.id_valid,    0);
    chk("rst_instr",    bus.id_instr,    0);
    chk("rst_pc",       bus.id_pc,       0);
    chk("rst_pc4",      bus.id_pc_plus4, 0);
    chk("rst_err",      bus.fetch_err,   0);
    chk("rst_pc_write", bus.pc_write,    0);
    bus.flush = 1'b0;
    #10;
    reset_i = 1'b0;
    #1;
    chk("idle_req", bus.imem_req, 0);

    // Zero-wait fetch
    step();
    chk("zw_req",      bus.imem_req,  1);
    chk("zw_addr",     bus.imem_addr, 32'h0);
    chk("zw_pcw_wait", bus.pc_write,  0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    #1;
    chk("zw_pcw_ack", bus.pc_write, 1);
    step();
    bus.imem_ack = 1'b0;
    bus.pc_in    = 32'h4;
    #1;
    chk("zw_valid", bus.id_valid,    1);
    chk("zw_instr", bus.id_instr,    32'h2008_0005);
    chk("zw_pc",    bus.id_pc,       32'h0);
    chk("zw_pc4",   bus.id_pc_plus4, 32'h4);
    chk("zw_req0",  bus.imem_req,    0);
    chk("zw_pcw0",  bus.pc_write,    0);

    // Wait states with backpressure
    step();
    chk("ws_req",   bus.imem_req,  1);
    chk("ws_addr",  bus.imem_addr, 32'h4);
    chk("ws_valid", bus.id_valid,  0);
    bus.id_ready = 1'b0;
    step();
    chk("ws_req2",  bus.imem_req,  1);
    chk("ws_addr2", bus.imem_addr, 32'h4);
    step();
    chk("ws_req3",  bus.imem_req,  1);
    chk("ws_addr3", bus.imem_addr, 32'h4);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h8C09_0004;
    #1;
    chk("ws_pcw", bus.pc_write, 1);
    step();
    bus.imem_ack = 1'b0;
    bus.pc_in    = 32'h8;
    #1;
    chk("ws_valid1", bus.id_valid,    1);
    chk("ws_instr",  bus.id_instr,    32'h8C09_0004);
    chk("ws_pc",     bus.id_pc,       32'h4);
    chk("ws_pc4",    bus.id_pc_plus4, 32'h8);
    step();
    chk("bp_valid", bus.id_valid, 1);
    chk("bp_req",   bus.imem_req, 0);
    step();
    chk("bp_valid2", bus.id_valid, 1);
    chk("bp_req2",   bus.imem_req, 0);
    bus.id_ready = 1'b1;
    step();
    chk("bp_rel_req",   bus.imem_req,  1);
    chk("bp_rel_addr",  bus.imem_addr, 32'h8);
    chk("bp_rel_valid", bus.id_valid,  0);

    // Flush while the request is in flight
    step();
    bus.flush = 1'b1;
    #1;
    chk("fl_pcw", bus.pc_write, 1);
    step();
    bus.flush = 1'b0;
    bus.pc_in = 32'h100;
    #1;
    chk("dr_req",   bus.imem_req,  1);
    chk("dr_addr",  bus.imem_addr, 32'h8);
    chk("dr_valid", bus.id_valid,  0);
    chk("dr_pcw",   bus.pc_write,  0);
    step();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("dr_ack_pcw", bus.pc_write, 0);
    step();
    bus.imem_ack = 1'b0;
    #1;
    chk("dr_done_valid", bus.id_valid, 0);
    chk("dr_done_instr", bus.id_instr, 32'h8C09_0004);
    chk("dr_done_req",   bus.imem_req, 0);
    step();
    chk("redir_req",  bus.imem_req,  1);
    chk("redir_addr", bus.imem_addr, 32'h100);

    // Flush coincident with ack
    bus.imem_ack   = 1'b1;
    bus.flush      = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    #1;
    chk("fa_pcw", bus.pc_write, 1);
    step();
    bus.imem_ack = 1'b0;
    bus.flush    = 1'b0;
    bus.pc_in    = 32'h6;
    #1;
    chk("fa_valid", bus.id_valid, 0);
    chk("fa_req",   bus.imem_req, 0);
    chk("fa_pcw0",  bus.pc_write, 0);
    chk("fa_instr", bus.id_instr, 32'h8C09_0004);
    chk("fa_err0",  bus.fetch_err, 0);

    // Misaligned PC
    step();
    bus.pc_in = 32'hFFFF_FFFC;
    #1;
    chk("mis_err", bus.fetch_err, 1);
    chk("mis_req", bus.imem_req,  0);

    // Top-of-address-space wrap
    step();
    chk("top_err0", bus.fetch_err, 0);
    chk("top_req",  bus.imem_req,  1);
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    step();
    bus.imem_ack = 1'b0;
    bus.pc_in    = 32'h40;
    #1;
    chk("top_valid", bus.id_valid,    1);
    chk("top_instr", bus.id_instr,    32'hCAFE_F00D);
    chk("top_pc",    bus.id_pc,       32'hFFFF_FFFC);
    chk("top_pc4",   bus.id_pc_plus4, 32'h0);

    // Asynchronous reset while in REQ
    step();
    chk("ar_req_pre", bus.imem_req, 1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h5555_5555;
    #1;
    chk("ar_pcw_pre", bus.pc_write, 1);
    reset_i = 1'b1;
    #1;
    chk("ar_req",   bus.imem_req,    0);
    chk("ar_addr",  bus.imem_addr,   0);
    chk("ar_valid", bus.id_valid,    0);
    chk("ar_pcw",   bus.pc_write,    0);
    chk("ar_instr", bus.id_instr,    0);
    chk("ar_pc",    bus.id_pc,       0);
    chk("ar_pc4",   bus.id_pc_plus4, 0);
    chk("ar_err",   bus.fetch_err,   0);
    bus.imem_ack = 1'b0;
    #10;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage between the program counter register and the ID stage.
- Samples the current PC, runs a req/ack transaction on an instruction memory with variable latency, and captures the returned word in a one-entry IF/ID output register with a valid/ready handshake.
- Drives the PC register's write enable so the PC advances only when a fetch is accepted or a redirect occurs.
- Handles branch/jump flush, including discarding a response that is already in flight.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- DATA_W, 32, instruction word width.
- NOP_WORD, 32'h00000000, value of id_instr at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_W  current PC from the program counter register.
- pc_write  out  1  PC register load enable (combinational).
- flush  in  1  redirect from branch/jump resolution.
- imem_req  out  1  instruction memory request.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1.
- imem_ack  in  1  memory response valid; one cycle per request.
- imem_rdata  in  DATA_W  instruction word, valid with imem_ack.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  ID stage accepts the instruction this cycle.
- id_instr  out  DATA_W  fetched instruction.
- id_pc  out  ADDR_W  address of id_instr.
- id_pc_plus4  out  ADDR_W  id_pc + 4.
- fetch_err  out  1  one-cycle pulse on a misaligned PC.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values:
  - state=IDLE, imem_req=0, imem_addr=0.
  - id_valid=0, id_instr=NOP_WORD, id_pc=0, id_pc_plus4=0.
  - fetch_err=0.
  - pc_write=0 while reset is high.
- slot_free = !id_valid | id_ready.
- Output register consumption: on id_valid & id_ready, id_valid clears at the next edge unless a capture occurs in the same cycle.
- IDLE:
  - flush=1: no request; pc_write=1; next state IDLE.
  - pc_in[1:0]!=0 and no flush: fetch_err=1 for the next cycle; no request; stay IDLE.
  - Otherwise, if slot_free: imem_req<=1, imem_addr<=pc_in, go to REQ.
  - Otherwise (slot occupied): stay IDLE.
- REQ:
  - imem_req=1 and imem_addr held.
  - imem_ack=1 and flush=0: accepted.
    - Capture at the edge: id_instr<=imem_rdata, id_pc<=imem_addr, id_pc_plus4<=imem_addr+4 (mod 2^ADDR_W, so 0xFFFFFFFC gives 0), id_valid<=1.
    - pc_write=1 in the ack cycle.
    - imem_req<=0; go to IDLE.
  - imem_ack=1 and flush=1: response discarded; id_valid<=0; pc_write=1; go to IDLE.
  - imem_ack=0 and flush=1: pc_write=1; id_valid<=0; go to DRAIN.
- DRAIN:
  - imem_req stays 1 and addr stays stable until ack; a request is never withdrawn.
  - On imem_ack: the data is dropped, imem_req<=0, go to IDLE.
  - flush while in DRAIN: pc_write=1, remain in DRAIN.
- Flush priority:
  - Flush in any state clears id_valid at the next edge and overrides capture.
  - pc_write = accepted_ack | flush, so the redirect target loads into the PC.
- Latency and throughput:
  - Minimum 2 cycles from pc_in sampled to id_valid, with ack in the first REQ cycle.
  - Maximum throughput is 1 instruction per 2 cycles.
- Request issue guarantees the slot is free at capture time, so no capture is ever lost or overwritten.
- Spurious imem_ack in IDLE is ignored.
- Reset asserted mid-transaction: immediate return to reset values. The memory is required to abandon its transaction on the same reset.

Test Plan:
- Zero-wait fetch: reset, pc_in=0x00000000, id_ready=1, ack one cycle after req with rdata=0x20080005. Required response:
  - imem_addr=0, pc_write pulses in the ack cycle.
  - Next cycle: id_valid=1, id_instr=0x20080005, id_pc=0, id_pc_plus4=4.
- Wait states with backpressure: ack 3 cycles after req, id_ready=0. Required response:
  - imem_req held 3 cycles with addr constant.
  - After capture, id_valid stays 1 and no new req is issued until id_ready=1; then req with the next pc_in.
- Flush in flight: flush pulsed in the 2nd REQ cycle, ack arrives 2 cycles later with 0xDEADBEEF. Required response:
  - State goes to DRAIN; pc_write=1 on the flush cycle.
  - id_valid stays 0; 0xDEADBEEF never appears on id_instr; after ack, req issued at the redirected pc_in.
- Flush coincident with ack: ack and flush in the same cycle. Required response:
  - id_valid=0 next cycle; pc_write=1 once; state IDLE.
- Boundaries:
  - pc_in=0x00000006: fetch_err pulses one cycle, imem_req stays 0.
  - pc_in=0xFFFFFFFC fetched: id_pc_plus4=0x00000000.
- Async reset in REQ: assert reset between clock edges. Required response:
  - imem_req, id_valid and pc_write drop immediately.
  - All outputs at reset values before the next clk edge.
